// File: rtl/win_banner_anim.sv
// Position/visibility generator for the "WIN" banner: slides up from below the
// screen, holds centred, then blinks until a new game clears it.
module win_banner_anim #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BANNER_W     = 298,
    parameter int BANNER_H     = 103,
    parameter int STEP         = 4,
    parameter int HOLD_FRAMES  = 120,
    parameter int BLINK_PERIOD = 30
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       frame_tick_i,
    input  logic       win_i,
    input  logic       clear_i,
    output logic [9:0] x_o,
    output logic [8:0] y_o,
    output logic       show_o,
    output logic       done_o
);

    localparam logic [9:0] CX      = 10'((SCREEN_W - BANNER_W) / 2);
    localparam logic [8:0] TY      = 9'((SCREEN_H - BANNER_H) / 2);
    localparam logic [8:0] Y_START = 9'(SCREEN_H);
    localparam logic [8:0] Y_STEP  = 9'(STEP);
    localparam int CNT_MAX = (HOLD_FRAMES > BLINK_PERIOD) ? HOLD_FRAMES : BLINK_PERIOD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        SLIDE,
        HOLD,
        BLINK
    } state_e;

    state_e             state_q, state_d;
    logic [9:0]         x_q;
    logic [8:0]         y_q, y_d;
    logic               show_q, show_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               win_q;
    logic               win_rise;

    assign win_rise = win_i & ~win_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            x_q     <= CX;
            y_q     <= Y_START;
            show_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= CX;
            y_q     <= y_d;
            show_q  <= show_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            win_q   <= win_i;
        end
    end

    // clear overrides every state; win edges only matter while idle
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        show_d  = show_q;
        done_d  = done_q;
        cnt_d   = cnt_q;

        if (clear_i) begin
            state_d = IDLE;
            y_d     = Y_START;
            show_d  = 1'b0;
            done_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    y_d    = Y_START;
                    show_d = 1'b0;
                    done_d = 1'b0;
                    cnt_d  = '0;
                    if (win_rise) begin
                        state_d = SLIDE;
                        show_d  = 1'b1;
                    end
                end
                SLIDE: begin
                    show_d = 1'b1;
                    if (frame_tick_i) begin
                        if (y_q <= TY + Y_STEP) begin
                            y_d     = TY;
                            cnt_d   = '0;
                            done_d  = 1'b1;
                            state_d = HOLD;
                        end else begin
                            y_d = y_q - Y_STEP;
                        end
                    end
                end
                HOLD: begin
                    show_d = 1'b1;
                    done_d = 1'b1;
                    if (frame_tick_i) begin
                        if (cnt_q == HOLD_LAST) begin
                            cnt_d   = '0;
                            state_d = BLINK;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                BLINK: begin
                    done_d = 1'b1;
                    if (frame_tick_i) begin
                        if (cnt_q == BLINK_LAST) begin
                            cnt_d  = '0;
                            show_d = ~show_q;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign show_o = show_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_win_banner_anim.sv
// Scoreboard bench for win_banner_anim: stimulus queues expected outputs,
// a monitor compares them one cycle later.
module tb_win_banner_anim;

    typedef struct {
        logic [8:0] y;
        logic       show;
        logic       done;
        string      tag;
    } expItem_t;

    logic       clk;
    logic       rstN;
    logic       frameTick;
    logic       win;
    logic       clear;
    logic [9:0] xOut;
    logic [8:0] yOut;
    logic       showOut;
    logic       doneOut;

    expItem_t   expQ[$];
    int         total = 0;
    int         bad   = 0;

    win_banner_anim dut (
        .clk_i        (clk),
        .rst_n_i      (rstN),
        .frame_tick_i (frameTick),
        .win_i        (win),
        .clear_i      (clear),
        .x_o          (xOut),
        .y_o          (yOut),
        .show_o       (showOut),
        .done_o       (doneOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input expItem_t e);
        total++;
        if (xOut !== 10'd171) begin
            bad++;
            $display("FAIL %s.x: actual=%0d required=171", e.tag, xOut);
        end
        total++;
        if (yOut !== e.y) begin
            bad++;
            $display("FAIL %s.y: actual=%0d required=%0d", e.tag, yOut, e.y);
        end
        total++;
        if (showOut !== e.show) begin
            bad++;
            $display("FAIL %s.show: actual=%b required=%b", e.tag, showOut, e.show);
        end
        total++;
        if (doneOut !== e.done) begin
            bad++;
            $display("FAIL %s.done: actual=%b required=%b", e.tag, doneOut, e.done);
        end
    endtask

    // monitor: one expectation per stimulus cycle, sampled just after the edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    task automatic applyStimulus(input logic r, input logic ft, input logic w, input logic cl,
                                 input logic [8:0] eY, input logic eShow, input logic eDone,
                                 input string tag);
        expItem_t e;
        @(negedge clk);
        rstN      = r;
        frameTick = ft;
        win       = w;
        clear     = cl;
        e.y    = eY;
        e.show = eShow;
        e.done = eDone;
        e.tag  = tag;
        expQ.push_back(e);
    endtask

    task automatic quiet(input int n, input logic w, input logic [8:0] eY,
                         input logic eShow, input logic eDone, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, w, 1'b0, eY, eShow, eDone, tag);
    endtask

    initial begin
        int gap;
        int expY;
        rstN = 1'b0; frameTick = 1'b0; win = 1'b0; clear = 1'b0;

        $display("[TB] reset");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 9'd480, 1'b0, 1'b0, "reset0");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 9'd480, 1'b0, 1'b0, "reset1");
        quiet(2, 1'b0, 9'd480, 1'b0, 1'b0, "idle");

        $display("[TB] slide");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 9'd480, 1'b1, 1'b0, "winRise");
        quiet(2, 1'b1, 9'd480, 1'b1, 1'b0, "slidePreTick");
        expY = 480;
        for (int k = 1; k <= 73; k++) begin
            expY = 480 - 4 * k;
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 9'(expY), 1'b1, (k == 73), "slideTick");
            gap = $urandom_range(1, 3);
            quiet(gap, 1'b1, 9'(expY), 1'b1, (k == 73), "slideStable");
        end

        $display("[TB] hold");
        for (int k = 1; k <= 120; k++) begin
            applyStimulus(1'b1, 1'b1, (k < 60), 1'b0, 9'd188, 1'b1, 1'b1, "holdTick");
            quiet(1, (k < 60), 9'd188, 1'b1, 1'b1, "holdStable");
        end

        $display("[TB] blink");
        for (int k = 1; k <= 30; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 9'd188, (k != 30), 1'b1, "blinkOff");
            quiet(1, 1'b0, 9'd188, (k != 30), 1'b1, "blinkOffStable");
        end
        for (int k = 1; k <= 30; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 9'd188, (k == 30), 1'b1, "blinkOn");
            quiet(1, 1'b1, 9'd188, (k == 30), 1'b1, "blinkOnStable");
        end

        $display("[TB] clear with tick in blink");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 9'd480, 1'b0, 1'b0, "clearTickBlink");
        quiet(3, 1'b1, 9'd480, 1'b0, 1'b0, "idleWinHeld");
        quiet(1, 1'b0, 9'd480, 1'b0, 1'b0, "winDrop");

        $display("[TB] coincident rise and tick");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 9'd480, 1'b1, 1'b0, "riseTick");
        quiet(1, 1'b1, 9'd480, 1'b1, 1'b0, "riseTickStable");
        for (int k = 1; k <= 45; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 9'(480 - 4 * k), 1'b1, 1'b0, "slide2Tick");
            quiet(1, 1'b1, 9'(480 - 4 * k), 1'b1, 1'b0, "slide2Stable");
        end

        $display("[TB] clear mid-slide");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 9'd480, 1'b0, 1'b0, "clearMidSlide");
        for (int k = 1; k <= 200; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 9'd480, 1'b0, 1'b0, "noMotion");
            quiet(1, 1'b1, 9'd480, 1'b0, 1'b0, "noMotionStable");
        end
        quiet(1, 1'b0, 9'd480, 1'b0, 1'b0, "winDrop2");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 9'd480, 1'b1, 1'b0, "reRise");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 9'd476, 1'b1, 1'b0, "restartTick1");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 9'd472, 1'b1, 1'b0, "restartTick2");
        quiet(2, 1'b1, 9'd472, 1'b1, 1'b0, "restartStable");

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL drain: actual=%0d pending required=0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
